// File: rtl/kalman_noise_pkg.sv
// Kalman noise matrix streamer shared package.
// State encoding, matrix selector codes and index helpers.
package kalman_noise_pkg;

  localparam int IDX_W = 4;

  localparam logic SEL_Q = 1'b0;
  localparam logic SEL_R = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    STREAM_Q,
    STREAM_R,
    DONE
  } stream_state_e;

  // +0 and -0 both count as zero: sign bit ignored
  function automatic logic fp64_is_zero(
    input logic [62:0] mag
  );
    return mag == '0;
  endfunction

endpackage

// File: rtl/mat_index_counter.sv
// Row-major element index for the Q or R matrix.
// sel picks which dimension bounds the walk.
module mat_index_counter
  import kalman_noise_pkg::*;
#(
  parameter int DIM_Q = 12,
  parameter int DIM_R = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             adv,
  input  logic             sel,
  output logic [IDX_W-1:0] row,
  output logic [IDX_W-1:0] col,
  output logic             at_last
);

  logic [IDX_W-1:0] lim;

  assign lim = sel ? IDX_W'(DIM_R - 1)
                   : IDX_W'(DIM_Q - 1);

  assign at_last = (row == lim) && (col == lim);

  // walk columns, wrap into the next row
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row <= '0;
      col <= '0;
    end else if (clr) begin
      row <= '0;
      col <= '0;
    end else if (adv) begin
      if (col == lim) begin
        col <= '0;
        row <= row + IDX_W'(1);
      end else begin
        col <= col + IDX_W'(1);
      end
    end
  end

endmodule

// File: rtl/noise_matrix_streamer.sv
// Snapshots Q_k/R_k on a matrices_ready rise and
// streams them row-major over valid/ready.
module noise_matrix_streamer
  import kalman_noise_pkg::*;
#(
  parameter int STATE_DIM   = 12,
  parameter int MEASURE_DIM = 6,
  parameter int SKIP_ZERO   = 0,
  parameter int SEND_R      = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [63:0]      Q_k [STATE_DIM][STATE_DIM],
  input  logic [63:0]      R_k [MEASURE_DIM][MEASURE_DIM],
  input  logic             matrices_ready,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [63:0]      m_data,
  output logic             m_sel,
  output logic [IDX_W-1:0] m_row,
  output logic [IDX_W-1:0] m_col,
  output logic             m_last,
  output logic             busy,
  output logic             done,
  output logic             overrun
);

  stream_state_e    state, state_n;
  logic             rdy_q, rise;
  logic             clr, adv, in_r;
  logic             at_last, skip;
  logic [IDX_W-1:0] row, col;
  logic [63:0]      q_sh [STATE_DIM][STATE_DIM];
  logic [63:0]      r_sh [MEASURE_DIM][MEASURE_DIM];
  logic [63:0]      q_el, r_el, el;

  assign rise = matrices_ready & ~rdy_q;
  assign in_r = (state == STREAM_R);

  mat_index_counter #(
    .DIM_Q (STATE_DIM),
    .DIM_R (MEASURE_DIM)
  ) u_idx (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (clr),
    .adv     (adv),
    .sel     (in_r),
    .row     (row),
    .col     (col),
    .at_last (at_last)
  );

  // edge detect, state register, sticky overrun
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q   <= 1'b0;
      state   <= IDLE;
      overrun <= 1'b0;
    end else begin
      rdy_q <= matrices_ready;
      state <= state_n;
      if (rise && busy)
        overrun <= 1'b1;
    end
  end

  // shadow copy taken only when a stream starts
  always_ff @(posedge clk) begin
    if (state == IDLE && rise) begin
      q_sh <= Q_k;
      r_sh <= R_k;
    end
  end

  // select the current element of each shadow
  always_comb begin
    q_el = '0;
    r_el = '0;
    for (int r = 0; r < STATE_DIM; r++)
      for (int c = 0; c < STATE_DIM; c++)
        if (row == IDX_W'(r) && col == IDX_W'(c))
          q_el = q_sh[r][c];
    for (int r = 0; r < MEASURE_DIM; r++)
      for (int c = 0; c < MEASURE_DIM; c++)
        if (row == IDX_W'(r) && col == IDX_W'(c))
          r_el = r_sh[r][c];
  end

  assign el   = in_r ? r_el : q_el;
  assign skip = (SKIP_ZERO != 0) && !at_last
             && fp64_is_zero(el[62:0]);

  // next state, stream outputs, index control
  always_comb begin
    state_n = state;
    m_valid = 1'b0;
    m_data  = '0;
    m_sel   = SEL_Q;
    m_row   = '0;
    m_col   = '0;
    m_last  = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    clr     = 1'b0;
    adv     = 1'b0;
    unique case (state)
      IDLE: begin
        if (rise) begin
          clr     = 1'b1;
          state_n = STREAM_Q;
        end
      end
      STREAM_Q, STREAM_R: begin
        busy   = 1'b1;
        m_sel  = in_r ? SEL_R : SEL_Q;
        m_data = el;
        m_row  = row;
        m_col  = col;
        m_last = at_last;
        if (skip) begin
          adv = 1'b1;
        end else begin
          m_valid = 1'b1;
          if (m_ready) begin
            if (!at_last) begin
              adv = 1'b1;
            end else begin
              clr     = 1'b1;
              state_n = (!in_r && SEND_R != 0)
                      ? STREAM_R : DONE;
            end
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_noise_matrix_streamer.sv
// Bench for noise_matrix_streamer: three configurations
// checked against a queue-based model of the stream.
`timescale 1ns/1ps

module tb_noise_matrix_streamer;

  typedef logic [73:0] beat_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m_ready;
  logic [2:0]  mr;
  logic [1:0]  dsel;
  logic [63:0] q12 [12][12];
  logic [63:0] r6  [6][6];
  logic [63:0] q4  [4][4];
  logic [63:0] r2  [2][2];

  logic [2:0]  vld, sel, lst, bsy, dn, ovr;
  logic [63:0] dat [3];
  logic [3:0]  rw  [3];
  logic [3:0]  cl  [3];

  logic        o_valid, o_busy, o_done, o_ovr;
  beat_t       o_beat;

  int    n_chk = 0;
  int    n_fail = 0;
  int    first_cyc, last_cyc, done_cyc, n_beats;
  beat_t exp_q [$];

  always #5 clk = ~clk;

  noise_matrix_streamer u0 (
    .clk(clk), .rst_n(rst_n), .Q_k(q12), .R_k(r6),
    .matrices_ready(mr[0]), .m_valid(vld[0]),
    .m_ready(m_ready), .m_data(dat[0]), .m_sel(sel[0]),
    .m_row(rw[0]), .m_col(cl[0]), .m_last(lst[0]),
    .busy(bsy[0]), .done(dn[0]), .overrun(ovr[0])
  );

  noise_matrix_streamer #(.SKIP_ZERO(1)) u1 (
    .clk(clk), .rst_n(rst_n), .Q_k(q12), .R_k(r6),
    .matrices_ready(mr[1]), .m_valid(vld[1]),
    .m_ready(m_ready), .m_data(dat[1]), .m_sel(sel[1]),
    .m_row(rw[1]), .m_col(cl[1]), .m_last(lst[1]),
    .busy(bsy[1]), .done(dn[1]), .overrun(ovr[1])
  );

  noise_matrix_streamer #(
    .STATE_DIM(4), .MEASURE_DIM(2), .SEND_R(0)
  ) u2 (
    .clk(clk), .rst_n(rst_n), .Q_k(q4), .R_k(r2),
    .matrices_ready(mr[2]), .m_valid(vld[2]),
    .m_ready(m_ready), .m_data(dat[2]), .m_sel(sel[2]),
    .m_row(rw[2]), .m_col(cl[2]), .m_last(lst[2]),
    .busy(bsy[2]), .done(dn[2]), .overrun(ovr[2])
  );

  always_comb begin
    o_valid = vld[dsel];
    o_busy  = bsy[dsel];
    o_done  = dn[dsel];
    o_ovr   = ovr[dsel];
    o_beat  = {sel[dsel], rw[dsel], cl[dsel],
               lst[dsel], dat[dsel]};
  end

  task automatic chk(
    input string tag,
    input logic [79:0] obs,
    input logic [79:0] expv
  );
    n_chk++;
    if (obs !== expv) begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, expv);
    end
  endtask

  function automatic logic [63:0] elem(
    input int m, input int sd, input int r, input int c
  );
    if (m == 0 && sd == 12) return q12[r][c];
    if (m == 0)             return q4[r][c];
    if (sd == 12)           return r6[r][c];
    return r2[r][c];
  endfunction

  task automatic build_exp(
    input int sd, input int md, input bit skip, input bit send_r
  );
    int d;
    logic [63:0] v;
    bit fin_el;
    exp_q.delete();
    for (int m = 0; m < (send_r ? 2 : 1); m++) begin
      d = (m == 0) ? sd : md;
      for (int r = 0; r < d; r++)
        for (int c = 0; c < d; c++) begin
          v = elem(m, sd, r, c);
          fin_el = (r == d - 1) && (c == d - 1);
          if (!skip || fin_el || v[62:0] != 63'd0)
            exp_q.push_back({m[0], r[3:0], c[3:0], fin_el, v});
        end
    end
  endtask

  task automatic load_gen();
    for (int r = 0; r < 12; r++)
      for (int c = 0; c < 12; c++) q12[r][c] = '0;
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 6; c++) r6[r][c] = '0;
    for (int a = 0; a < 3; a++) begin
      q12[2*a][2*a]     = 64'h3FD5555555555555;
      q12[2*a][2*a+1]   = 64'h3FE0000000000000;
      q12[2*a+1][2*a]   = 64'h3FE0000000000000;
      q12[2*a+1][2*a+1] = 64'h3FF0000000000000;
    end
    q12[7][3] = 64'h8000000000000000;
    for (int i = 0; i < 6; i++) r6[i][i] = 64'h3FB999999999999A;
    r6[0][1] = 64'h8000000000000000;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) q4[r][c] = {$urandom, $urandom};
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++) r2[r][c] = {$urandom, $urandom};
  endtask

  task automatic rand_inputs();
    for (int r = 0; r < 12; r++)
      for (int c = 0; c < 12; c++) q12[r][c] = {$urandom, $urandom};
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 6; c++) r6[r][c] = {$urandom, $urandom};
  endtask

  task automatic check_reset(input string tag);
    logic [77:0] v;
    v = {o_valid, o_busy, o_done, o_ovr, o_beat};
    chk(tag, v, 80'd0);
  endtask

  task automatic rise(input int i);
    @(negedge clk);
    mr[i] = 1'b1;
  endtask

  task automatic consume(
    input int pct, input int act, input int act_beat,
    input bit keep, input int budget
  );
    bit fin, acted;
    fin = 0; acted = 0;
    first_cyc = -1; last_cyc = -1; done_cyc = -1; n_beats = 0;
    for (int cyc = 0; cyc < budget && !fin; cyc++) begin
      @(negedge clk);
      if (cyc == 1 && !keep) mr[dsel] = 1'b0;
      m_ready = ($urandom_range(0, 99) < pct);
      if (act != 0 && !acted && n_beats == act_beat) begin
        acted = 1;
        if (act == 1) begin
          rand_inputs();
          mr[dsel] = 1'b1;
        end else begin
          rst_n = 1'b0;
          #1;
          check_reset("mid_reset");
          return;
        end
      end
      #1;
      if (o_valid) begin
        if (first_cyc < 0) first_cyc = cyc;
        if (exp_q.size() == 0) chk("extra_beat", o_valid, 0);
        else begin
          chk("beat", o_beat, exp_q[0]);
          chk("busy", o_busy, 1);
          if (m_ready) begin
            void'(exp_q.pop_front());
            n_beats++;
            last_cyc = cyc;
          end
        end
      end else if (n_beats > 0 && exp_q.size() == 0) begin
        chk("done", o_done, 1);
        chk("done_busy", o_busy, 0);
        fin = 1;
        done_cyc = cyc;
      end else chk("no_done", o_done, 0);
    end
    if (!fin) chk("timeout", fin, 1);
  endtask

  initial begin
    rst_n = 1'b0; m_ready = 1'b0; mr = '0; dsel = 2'd0;
    load_gen();
    repeat (3) @(negedge clk);
    #1 check_reset("reset_state");
    @(negedge clk) rst_n = 1'b1;

    build_exp(12, 6, 0, 1);
    rise(0);
    consume(100, 0, 0, 1, 400);
    chk("t1_beats", n_beats, 180);
    chk("t1_latency", first_cyc, 0);
    chk("t1_contig", last_cyc - first_cyc + 1, 180);
    chk("t1_done_lat", done_cyc - last_cyc, 1);
    repeat (4) begin
      @(negedge clk); #1;
      chk("t1_no_restream", o_valid, 0);
      chk("t1_done_once", o_done, 0);
    end
    mr[0] = 1'b0;

    rand_inputs();
    build_exp(12, 6, 0, 1);
    rise(0);
    consume(50, 0, 0, 0, 2000);
    chk("t2_beats", n_beats, 180);
    chk("t2_no_overrun", o_ovr, 0);

    dsel = 2'd1;
    load_gen();
    build_exp(12, 6, 1, 1);
    rise(1);
    consume(100, 0, 0, 0, 400);
    chk("t3_beats", n_beats, 19);

    dsel = 2'd0;
    rand_inputs();
    build_exp(12, 6, 0, 1);
    rise(0);
    consume(100, 1, 50, 0, 400);
    chk("t4_beats", n_beats, 180);
    chk("t4_overrun", o_ovr, 1);

    @(negedge clk) mr[0] = 1'b0;
    @(negedge clk);
    build_exp(12, 6, 0, 1);
    rise(0);
    consume(100, 2, 70, 0, 400);
    chk("t5_beats_before", n_beats, 70);
    @(negedge clk) rst_n = 1'b1;
    #1 check_reset("t5_after_reset");
    build_exp(12, 6, 0, 1);
    rise(0);
    consume(100, 0, 0, 0, 400);
    chk("t5_beats", n_beats, 180);
    chk("t5_latency", first_cyc, 0);

    dsel = 2'd2;
    build_exp(4, 2, 0, 0);
    rise(2);
    consume(100, 0, 0, 0, 100);
    chk("t6_beats", n_beats, 16);
    chk("t6_done_lat", done_cyc - last_cyc, 1);
    mr[2] = 1'b1;
    repeat (3) begin
      @(negedge clk); #1;
      chk("t6_no_restream", o_valid, 0);
      chk("t6_no_overrun", o_ovr, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/noise_matrix_streamer.md
Name: noise_matrix_streamer

Overview:
Downstream consumer of the noise generator. On each rising edge of matrices_ready it snapshots Q_k (STATE_DIM x STATE_DIM) and R_k (MEASURE_DIM x MEASURE_DIM). It then streams the elements, row-major, over a valid/ready interface tagged with matrix/row/col. The Kalman predict/update datapath consumes this stream and loads Q into the P-prediction adder and R into the innovation-covariance adder.

Parameters:
STATE_DIM, 12, Q dimension; 2..16
MEASURE_DIM, 6, R dimension; 1..16
SKIP_ZERO, 0, 1 = suppress elements whose bits[62:0]==0 (+0/-0), except each matrix's final element
SEND_R, 1, 1 = stream R after Q; 0 = stream Q only

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
Q_k  in  64 x [STATE_DIM][STATE_DIM]  process noise, IEEE754-64
R_k  in  64 x [MEASURE_DIM][MEASURE_DIM]  measurement noise, IEEE754-64
matrices_ready  in  1  level; rising edge = new matrices valid
m_valid  out  1  stream element valid
m_ready  in  1  consumer ready
m_data  out  64  element bits
m_sel  out  1  0 = Q, 1 = R
m_row  out  4  row index
m_col  out  4  column index
m_last  out  1  final beat of the current matrix
busy  out  1  high in STREAM_Q/STREAM_R
done  out  1  one-cycle pulse after final handshake
overrun  out  1  sticky; rising edge seen while busy

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low, rst_n.
- Reset values: state=IDLE, m_valid=0, m_data=0, m_sel=0, m_row=0, m_col=0, m_last=0, busy=0, done=0, overrun=0, rdy_q (registered matrices_ready)=0. Shadow arrays are not reset.
- Edge detect: rise = matrices_ready & ~rdy_q. rdy_q updates every cycle.
- IDLE:
  - On rise, snapshot all Q_k and R_k into shadow registers at that edge, set row=col=0, go to STREAM_Q.
  - m_valid is first high the following cycle, i.e. 1 cycle of latency.
- STREAM_Q:
  - Present shadow Q[row][col]; m_sel=0.
  - A beat completes when m_valid & m_ready. Index then advances col++; when col reaches STATE_DIM-1 it wraps to 0 and row++.
  - m_last=1 when row=col=STATE_DIM-1.
  - After the last beat: go to STREAM_R with row=col=0 if SEND_R=1, else go to DONE.
- STREAM_R: same as STREAM_Q with MEASURE_DIM; m_sel=1. After the last beat go to DONE.
- DONE: done=1 for exactly this cycle, busy=0, m_valid=0, then go to IDLE.
- AXI-style stability: while m_valid & ~m_ready, m_data/m_sel/m_row/m_col/m_last are held constant. m_valid never deasserts without a handshake, except on reset.
- SKIP_ZERO=1:
  - At a zero-valued non-final position, m_valid=0 for one cycle and the index advances. Cost is 1 cycle per skipped element.
  - The final element of each matrix is always emitted, even if zero, so m_last is always delivered.
- Throughput: with m_ready held high and SKIP_ZERO=0, there is one beat per cycle. Q takes STATE_DIM² cycles and R takes MEASURE_DIM² cycles. Defaults: 144+36=180 beats, and done pulses 1 cycle after the 180th handshake.
- Retrigger:
  - A rise while busy is ignored (no re-snapshot) and sets overrun. overrun clears only on reset.
  - If matrices_ready is still high on return to IDLE there is no new rise, so no restream.
  - A rise coincident with the DONE cycle is ignored but does not set overrun.
- Reset mid-stream: abort immediately; all outputs go to reset values. The next rise restarts from Q[0][0].
- Input changes after the snapshot have no effect on the stream in flight.

Decomposition:
- Package kalman_noise_pkg:
  - enum stream_state_e {IDLE, STREAM_Q, STREAM_R, DONE}
  - localparams SEL_Q=1'b0, SEL_R=1'b1
  - function fp64_is_zero (bits[62:0]==0)
  - index width constant IDX_W=4
- Sub-module mat_index_counter (params DIM; ports clk, rst_n, clr, adv, row, col, at_last). Used once, reloaded between matrices.

Test Plan:
- Defaults, generator-style Q (3 axes of pos/vel blocks) and R diag 0.1 (0x3FB999999999999A), m_ready=1 -> 180 beats in 180 consecutive cycles; beat 0 is Q[0][0]; m_last at beats 143 and 179; m_sel flips at beat 144; done 1 cycle after beat 179.
- Random m_ready (50%) -> every beat matches the snapshot in order; outputs stable during stalls; no beat dropped or duplicated.
- SKIP_ZERO=1, same matrices -> Q emits 12 nonzero beats plus zero Q[11][11] with m_last (13 total); R emits 6 diagonal beats, last R[5][5].
- Second matrices_ready rise at beat 50 with altered inputs -> overrun=1; stream continues with original snapshot values; 180 beats total.
- rst_n low at beat 70 -> m_valid=0 and all outputs at reset values; after reset, a new rise restarts at Q[0][0].
- SEND_R=0, STATE_DIM=4 -> 16 beats, m_last on beat 15, done next cycle, no m_sel=1 beat.
